// File: rtl/gdcapture_pkg.sv
// rtl/gdcapture_pkg.sv - shared GVRAM frame constants and helpers for the pixel capture path
package gdcapture_pkg;

  localparam int GVRAM_BYTES_PER_FRAME = 8000;
  localparam int GVRAM_ADDR_W          = 13;

  typedef logic [7:0] pix_byte_t;

  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned n);
    return (a == n - 1) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/gdcapture_if.sv
// rtl/gdcapture_if.sv - GVRAM write request bus between capture and arbiter
interface gdcapture_if #(
  parameter int ADDR_W = gdcapture_pkg::GVRAM_ADDR_W
);
  logic              WREQ;
  logic [7:0]        WDATA;
  logic [ADDR_W-1:0] WADDR;
  logic              WACK;

  modport master (output WREQ, output WDATA, output WADDR, input WACK);
  modport slave  (input WREQ, input WDATA, input WADDR, output WACK);
endinterface

// File: rtl/gdcap_shift.sv
// rtl/gdcap_shift.sv - LSB-first pixel shifter; flags each completed byte, clears in blanking
module gdcap_shift
  import gdcapture_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      active,
  input  logic      pixen,
  input  logic      gdat,
  output logic      byte_done,
  output pix_byte_t byte_val
);

  pix_byte_t  sh_q, sh_d;
  logic [2:0] bcnt_q, bcnt_d;

  always_comb begin
    sh_d   = sh_q;
    bcnt_d = bcnt_q;
    if (!active) begin
      sh_d   = '0;
      bcnt_d = '0;
    end else if (pixen) begin
      sh_d   = {gdat, sh_q[7:1]};
      bcnt_d = bcnt_q + 3'd1;
    end
  end

  // Blanking wins over a coincident 8th strobe, so done is gated by active
  assign byte_done = active && pixen && (bcnt_q == 3'd7);
  assign byte_val  = {gdat, sh_q[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      bcnt_q <= '0;
    end else begin
      sh_q   <= sh_d;
      bcnt_q <= bcnt_d;
    end
  end

endmodule

// File: rtl/gdcapture.sv
// rtl/gdcapture.sv - pixel stream to GVRAM byte writes: holding register, frame address, overrun, frame-done
module gdcapture
  import gdcapture_pkg::*;
#(
  parameter int BYTES_PER_FRAME = GVRAM_BYTES_PER_FRAME,
  parameter int ADDR_W          = GVRAM_ADDR_W
)(
  input  logic CLK,
  input  logic nRST,
  input  logic nHBLANK,
  input  logic nVBLANK,
  input  logic PIXEN,
  input  logic GDAT,
  input  logic OVRCLR,
  output logic OVR,
  output logic FDONE,
  gdcapture_if.master wr
);

  logic      byte_done;
  pix_byte_t byte_val;

  gdcap_shift u_shift (
    .clk       (CLK),
    .rst_n     (nRST),
    .active    (nHBLANK && nVBLANK),
    .pixen     (PIXEN),
    .gdat      (GDAT),
    .byte_done (byte_done),
    .byte_val  (byte_val)
  );

  logic [ADDR_W-1:0] acnt_q, acnt_d;
  logic              wreq_q, wreq_d;
  pix_byte_t         wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              ovr_q, ovr_d;
  logic              vbl_q, vbl_d;
  logic              fdone_q, fdone_d;
  logic              ovr_set;

  always_comb begin
    acnt_d  = acnt_q;
    wreq_d  = wreq_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    ovr_set = 1'b0;

    if (!nVBLANK) begin
      acnt_d = '0;
    end else if (byte_done) begin
      acnt_d = ADDR_W'(wrap_inc(32'(acnt_q), 32'(BYTES_PER_FRAME)));
    end

    // A new byte may replace the pending one only if the arbiter takes it this cycle
    if (byte_done) begin
      if (!wreq_q || wr.WACK) begin
        wreq_d  = 1'b1;
        wdata_d = byte_val;
        waddr_d = acnt_q;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (wreq_q && wr.WACK) begin
      wreq_d = 1'b0;
    end

    ovr_d = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (OVRCLR) begin
      ovr_d = 1'b0;
    end

    vbl_d   = nVBLANK;
    fdone_d = vbl_q && !nVBLANK;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acnt_q  <= '0;
      wreq_q  <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      ovr_q   <= 1'b0;
      vbl_q   <= 1'b1;
      fdone_q <= 1'b0;
    end else begin
      acnt_q  <= acnt_d;
      wreq_q  <= wreq_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      ovr_q   <= ovr_d;
      vbl_q   <= vbl_d;
      fdone_q <= fdone_d;
    end
  end

  assign wr.WREQ  = wreq_q;
  assign wr.WDATA = wdata_q;
  assign wr.WADDR = waddr_q;
  assign OVR      = ovr_q;
  assign FDONE    = fdone_q;

endmodule

// File: tb/tb_gdcapture.sv
// tb/tb_gdcapture.sv - scoreboard bench for gdcapture
module tb_gdcapture;

  localparam int BPF = 8000;
  localparam int AW  = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nhb = 1'b0;
  logic nvb = 1'b0;
  logic pixen = 1'b0;
  logic gdat = 1'b0;
  logic ovrclr = 1'b0;
  logic wack_man = 1'b0;
  logic auto_ack = 1'b0;
  logic ovr, fdone;

  gdcapture_if #(.ADDR_W(AW)) wr ();
  assign wr.WACK = auto_ack ? wr.WREQ : wack_man;

  gdcapture #(.BYTES_PER_FRAME(BPF), .ADDR_W(AW)) dut (
    .CLK     (clk),
    .nRST    (rst_n),
    .nHBLANK (nhb),
    .nVBLANK (nvb),
    .PIXEN   (pixen),
    .GDAT    (gdat),
    .OVRCLR  (ovrclr),
    .OVR     (ovr),
    .FDONE   (fdone),
    .wr      (wr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [20:0] exp_q[$];
  int exp_addr = 0;
  logic prev_wreq = 1'b0;
  logic prev_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit push, input bit ack_last);
    logic [12:0] a;
    a = exp_addr[12:0];
    if (push) exp_q.push_back({a, d});
    exp_addr = (exp_addr == BPF - 1) ? 0 : exp_addr + 1;
    for (int i = 0; i < 8; i++) begin
      pixen = 1'b1;
      gdat  = d[i];
      if (ack_last && i == 7) wack_man = 1'b1;
      tick();
    end
    pixen    = 1'b0;
    gdat     = 1'b0;
    wack_man = 1'b0;
  endtask

  task automatic vblank_pulse();
    nvb = 1'b0;
    tick();
    nvb = 1'b1;
    tick();
    exp_addr = 0;
  endtask

  // Monitor: each fresh presentation of a request is matched against the queue
  always @(negedge clk) begin
    logic [20:0] e;
    if (wr.WREQ && (!prev_wreq || prev_acc)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got data %0h addr %0h expected none", wr.WDATA, wr.WADDR);
      end else begin
        e = exp_q.pop_front();
        chk("wdata", {24'd0, wr.WDATA}, {24'd0, e[7:0]});
        chk("waddr", {19'd0, wr.WADDR}, {19'd0, e[20:8]});
      end
    end
    prev_wreq <= wr.WREQ;
    prev_acc  <= wr.WREQ && wr.WACK;
  end

  initial begin
    repeat (3) tick();
    chk("rst_wreq", {31'd0, wr.WREQ}, 32'd0);
    chk("rst_wdata", {24'd0, wr.WDATA}, 32'd0);
    chk("rst_waddr", {19'd0, wr.WADDR}, 32'd0);
    chk("rst_ovr", {31'd0, ovr}, 32'd0);
    chk("rst_fdone", {31'd0, fdone}, 32'd0);
    nhb = 1'b1;
    nvb = 1'b1;
    rst_n = 1'b1;
    tick();

    // first byte 0x85, held until acknowledged
    send(8'h85, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_wreq_held", {31'd0, wr.WREQ}, 32'd1);
    @(posedge clk); #1;
    wack_man = 1'b1;
    tick();
    wack_man = 1'b0;
    @(negedge clk);
    chk("t1_wreq_drop", {31'd0, wr.WREQ}, 32'd0);

    // 40 bytes with acknowledge tied to request
    auto_ack = 1'b1;
    tick();
    vblank_pulse();
    for (int i = 0; i < 40; i++) send(8'(i * 7 + 3), 1'b1, 1'b0);
    repeat (2) tick();
    chk("t2_ovr", {31'd0, ovr}, 32'd0);

    // partial byte then horizontal blanking is discarded
    for (int i = 0; i < 5; i++) begin
      pixen = 1'b1;
      gdat  = 1'b1;
      tick();
    end
    pixen = 1'b0;
    nhb = 1'b0;
    tick();
    nhb = 1'b1;
    send(8'hFF, 1'b1, 1'b0);
    repeat (2) tick();

    // overrun: second byte dropped while the first waits
    auto_ack = 1'b0;
    send(8'h3C, 1'b1, 1'b0);
    send(8'hC3, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_ovr_set", {31'd0, ovr}, 32'd1);
    chk("t4_hold_data", {24'd0, wr.WDATA}, 32'h3C);
    chk("t4_hold_addr", {19'd0, wr.WADDR}, 32'd41);
    @(posedge clk); #1;
    wack_man = 1'b1;
    tick();
    wack_man = 1'b0;
    auto_ack = 1'b1;
    send(8'h5A, 1'b1, 1'b0);
    tick();
    ovrclr = 1'b1;
    tick();
    ovrclr = 1'b0;
    @(negedge clk);
    chk("t4_ovr_clr", {31'd0, ovr}, 32'd0);

    // full frame plus one byte wraps to address 0
    @(posedge clk); #1;
    vblank_pulse();
    for (int i = 0; i <= BPF; i++) send(8'(i ^ 8'h5A), 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_wrap_addr", {19'd0, wr.WADDR}, 32'd0);
    @(posedge clk); #1;
    nvb = 1'b0;
    @(negedge clk);
    chk("t5_fdone_pre", {31'd0, fdone}, 32'd0);
    @(negedge clk);
    chk("t5_fdone_hi", {31'd0, fdone}, 32'd1);
    @(negedge clk);
    chk("t5_fdone_lo", {31'd0, fdone}, 32'd0);
    @(posedge clk); #1;
    nvb = 1'b1;
    tick();
    exp_addr = 0;
    send(8'hE7, 1'b1, 1'b0);
    repeat (2) tick();

    // byte completes in the acknowledge cycle, then async reset mid-request
    auto_ack = 1'b0;
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_wreq_kept", {31'd0, wr.WREQ}, 32'd1);
    chk("t6_ovr", {31'd0, ovr}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", {31'd0, wr.WREQ}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gdcapture.md
# gdcapture

Serial-to-parallel capture of the 1-bit graphic pixel stream back into GVRAM bytes, the inverse of the graphic data output serializer. Runs at the 16 MHz pixel clock domain. Samples GDAT on each pixel strobe during active video and assembles 8 pixels LSB-first, so the first pixel lands in bit 0. Each completed byte goes out as a registered write request with a frame-relative address toward the GVRAM arbiter.

## Interface
- BYTES_PER_FRAME, 8000: bytes per frame (40 bytes × 200 lines); address wraps to 0 after BYTES_PER_FRAME-1.
- ADDR_W, 13: width of WADDR.

Ports:
- CLK  in  1  16 MHz clock; all logic on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- nHBLANK  in  1  low = horizontal blanking.
- nVBLANK  in  1  low = vertical blanking.
- PIXEN  in  1  pixel strobe; GDAT is valid when high.
- GDAT  in  1  serial pixel data.
- WACK  in  1  arbiter accepts the current request.
- OVRCLR  in  1  clears OVR.
- WREQ  out  1  write request; held until acknowledged.
- WDATA  out  8  byte to write; stable while WREQ=1.
- WADDR  out  ADDR_W  byte address; stable while WREQ=1.
- OVR  out  1  sticky overrun flag.
- FDONE  out  1  one-cycle pulse at the start of vertical blanking.

## Operation
- Active video means nHBLANK=1 and nVBLANK=1.
- Shift stage, active video with PIXEN=1: sh <= {GDAT, sh[7:1]} and bcnt increments mod 8. On the 8th bit (bcnt==7), the completed byte {GDAT, sh[7:1]} goes to the holding stage.
- Outside active video: sh <= 0 and bcnt <= 0. A partial byte is discarded and does not advance the address.
- Address counter acnt increments once per completed byte. Next value after BYTES_PER_FRAME-1 is 0. Forced to 0 while nVBLANK=0.
- Holding stage, when a byte completes:
  - WREQ=0: WDATA <= byte, WADDR <= acnt, WREQ <= 1.
  - WREQ=1 and WACK=1 in the same cycle: reload with the new byte/address; WREQ stays 1; no overrun.
  - WREQ=1 and WACK=0: the byte is dropped, OVR <= 1, acnt still advances (keeps alignment).
- Handshake: WACK is sampled only while WREQ=1; WACK with WREQ=0 is ignored. With WREQ=1, WACK=1 and no new byte, WREQ <= 0 next cycle.
- OVR: OVRCLR=1 clears it. If a set condition occurs in the same cycle, set wins.
- FDONE: registered edge detect of nVBLANK 1→0; high for exactly one CLK.

## Timing
- Reset values: WREQ=0, WDATA=0, WADDR=0, OVR=0, FDONE=0. Internal sh=0, bcnt=0, acnt=0, nVBLANK edge register=1.
- Latency: WREQ, WDATA and WADDR are valid on the rising edge that samples the 8th PIXEN (visible the cycle after).
- Minimum spacing between requests is 8 PIXEN strobes. The arbiter must acknowledge within 8 strobes to avoid overrun.
- Blanking asserted in the same cycle as the 8th strobe: the byte is discarded and bcnt resets. Blanking has priority.
- nVBLANK falling: FDONE rises the next edge. A pending WREQ is unaffected and keeps its latched address.
- nRST low mid-request: WREQ drops immediately (asynchronous). The in-flight byte is lost.

## Structure
- Shared defines include (gvram_defs.vh) holds GVRAM_BYTES_PER_FRAME (8000) and GVRAM_ADDR_W (13). These are the parameter defaults and are also used by the serializer-side address generator.
- One natural sub-module: gdcap_shift (sh, bcnt, blank clear). It outputs byte_done and byte_val. Holding, address, OVR and FDONE logic live in the top.

## Test plan
- Reset, then 8 strobes of active video with GDAT = 1,0,1,0,0,0,0,1 → one WREQ, WDATA=8'h85, WADDR=0. After WACK, WREQ falls the next cycle.
- 40 bytes with WACK tied to WREQ → WADDR runs 0..39 and OVR stays 0.
- 5 strobes, then nHBLANK=0, then 8 strobes of 0xFF → only byte 0xFF is written, at the next address; the partial byte is discarded.
- Hold WACK=0 across two completed bytes → OVR=1, only the first byte is presented, and the next accepted byte's address is skipped by one. OVRCLR → OVR=0.
- Drive BYTES_PER_FRAME+1 bytes without blanking → the last byte has WADDR=0 (wrap). Then drop nVBLANK → FDONE is a single-cycle pulse and acnt=0.
- Byte completes in the same cycle as WACK → WREQ stays high, new WDATA/WADDR appear, and OVR stays 0. Assert nRST mid-request → WREQ=0 at once.
